// File: rtl/logic_unit_pipe.sv
// Registered eight-function bitwise logic unit with a folding accumulator,
// saturating beat counter and a one-entry valid/ready output stage.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             y_par,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] res;
   logic             vld_q, vld_d;
   logic             zero_q, zero_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   function automatic logic [WIDTH-1:0] bit_op(input logic [2:0]       sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
      logic [WIDTH-1:0] r;
      case (sel)
         3'd0:    r = x & z;
         3'd1:    r = x | z;
         3'd2:    r = x ^ z;
         3'd3:    r = ~(x & z);
         3'd4:    r = ~(x | z);
         3'd5:    r = ~(x ^ z);
         3'd6:    r = x & ~z;
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Downstream slot frees up in the same cycle it is drained, so streaming has no bubble.
   assign in_ready = !vld_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign b_eff    = acc_mode ? acc_q : b;
   assign res      = acc_clr ? a : bit_op(op, a, b_eff);

   always_comb begin
      acc_d  = acc_q;
      y_d    = y_q;
      zero_d = zero_q;
      par_d  = par_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      if (accept) begin
         y_d    = res;
         zero_d = (res == '0);
         par_d  = ^res;
         cnt_d  = sat_inc(cnt_q);
         vld_d  = 1'b1;
         if (acc_clr || acc_mode) acc_d = res;
      end else if (out_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         y_q    <= '0;
         zero_q <= 1'b1;
         par_q  <= 1'b0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         y_q    <= y_d;
         zero_q <= zero_d;
         par_q  <= par_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   assign out_valid = vld_q;
   assign y         = y_q;
   assign y_zero    = zero_q;
   assign y_par     = par_q;
   assign count     = cnt_q;

endmodule
